// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dmem_arbiter                                                 |
// | Description : Round-robin arbiter that shares one data-memory port among   |
// |               NCORES per-core requesters. Grants one core, drives the      |
// |               shared memory for MEM_LAT cycles, returns read data and      |
// |               pulses done to the granted core.                             |
// | Option      : DMEM_ARB_FIXED_PRIO_EN - core 0 always wins when requesting; |
// |               the remaining cores rotate among themselves.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dmem_arbiter #(
  parameter int NCORES  = 4,
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int MEM_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCORES-1:0]    req_i,
  input  logic [NCORES-1:0]    we_i,
  input  logic [NCORES*AW-1:0] addr_i,
  input  logic [NCORES*DW-1:0] wdata_i,
  output logic [NCORES-1:0]    gnt_o,
  output logic [NCORES-1:0]    done_o,
  output logic [DW-1:0]        rdata_o,
  output logic                 mem_en_o,
  output logic                 mem_we_o,
  output logic [AW-1:0]        mem_addr_o,
  output logic [DW-1:0]        mem_wdata_o,
  input  logic [DW-1:0]        mem_rdata_i
);

  localparam int IW = $clog2(NCORES);
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]       gidx_q, gidx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NCORES-1:0]   gnt_q, gnt_d;
  logic [NCORES-1:0]   done_q, done_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [AW-1:0]       mem_addr_q, mem_addr_d;
  logic [DW-1:0]       mem_wdata_q, mem_wdata_d;

  logic [NCORES-1:0]   arb_req;
  logic                arb_found;
  logic [IW-1:0]       arb_idx;
  int                  cand;

  // Pick the first requester at or after rr_ptr, wrapping around the core list
  always_comb begin
    arb_req   = req_i;
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    // Core 0 is handled by the priority override below, so it never rotates
    arb_req[0] = 1'b0;
`endif
    for (int k = 0; k < NCORES; k++) begin
      cand = (int'(rr_ptr_q) + k) % NCORES;
      if (!arb_found && arb_req[IW'(cand)]) begin
        arb_found = 1'b1;
        arb_idx   = IW'(cand);
      end
    end
`ifdef DMEM_ARB_FIXED_PRIO_EN
    if (req_i[0]) begin
      arb_found = 1'b1;
      arb_idx   = '0;
    end
`endif
  end

  // State and datapath registers; async reset abandons any in-flight access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      gidx_q      <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gidx_q      <= gidx_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Next-state logic: IDLE grants and latches the request, ACCESS counts out
  // the memory latency, DONE holds the grant for the single done cycle
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gidx_d      = gidx_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    done_d      = done_q;
    rdata_d     = rdata_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          gidx_d      = arb_idx;
          gnt_d       = NCORES'(1) << arb_idx;
          mem_en_d    = 1'b1;
          mem_we_d    = we_i[arb_idx];
          mem_addr_d  = addr_i[arb_idx*AW +: AW];
          mem_wdata_d = wdata_i[arb_idx*DW +: DW];
          cnt_d       = '0;
          state_d     = S_ACCESS;
        end
      end

      S_ACCESS: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          // Writes leave the last read value visible on rdata
          if (!mem_we_q) begin
            rdata_d = mem_rdata_i;
          end
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          done_d   = gnt_q;
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        done_d = '0;
        gnt_d  = '0;
        if (gidx_q == IW'(NCORES - 1)) begin
          rr_ptr_d = '0;
        end else begin
          rr_ptr_d = gidx_q + IW'(1);
        end
`ifdef DMEM_ARB_FIXED_PRIO_EN
        // Priority grants to core 0 do not disturb the rotation of the others
        if (gidx_q == '0) begin
          rr_ptr_d = rr_ptr_q;
        end else if (rr_ptr_d == '0) begin
          rr_ptr_d = IW'(1);
        end
`endif
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign rdata_o     = rdata_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_dmem_arbiter                                              |
// | Description : Scoreboard bench for dmem_arbiter with a latency-aware       |
// |               memory model and directed request sequences.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_dmem_arbiter;

  localparam int NCORES  = 4;
  localparam int AW      = 8;
  localparam int DW      = 8;
  localparam int MEM_LAT = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCORES-1:0]    req, we;
  logic [NCORES*AW-1:0] addr;
  logic [NCORES*DW-1:0] wdata;
  logic [NCORES-1:0]    gnt, done;
  logic [DW-1:0]        rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]        mem_addr;
  logic                 mem_en, mem_we;

  always #5 clk = ~clk;

  dmem_arbiter #(.NCORES(NCORES), .AW(AW), .DW(DW), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .gnt_o(gnt), .done_o(done), .rdata_o(rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  // Memory model: read data is only valid once mem_en has been up MEM_LAT cycles
  logic [DW-1:0] mem [256];
  int en_cyc = 0;
  int cyc = 0;

  function automatic logic [DW-1:0] pre(input logic [AW-1:0] a);
    if (a == 8'h3C) return 8'hA5;
    return (a ^ 8'h5A) + 8'h11;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    en_cyc <= mem_en ? en_cyc + 1 : 0;
  end

  assign mem_rdata = (mem_en && en_cyc >= MEM_LAT - 1) ? mem[mem_addr] : 8'hEE;

  // Scoreboard
  typedef struct {
    int           core;
    logic [DW-1:0] rd;
  } exp_t;
  exp_t sbq[$];
  logic [DW-1:0] exp_rd = '0;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_read(input int core, input logic [AW-1:0] a);
    exp_rd = pre(a);
    sbq.push_back('{core: core, rd: exp_rd});
  endtask

  task automatic push_write(input int core);
    sbq.push_back('{core: core, rd: exp_rd});
  endtask

  task automatic wait_any_done(output logic [NCORES-1:0] d);
    d = '0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (done != '0) begin
        d = done;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL done_timeout: got no done within 20 cycles (t=%0t)", $time);
  endtask

  // Monitor: every done pulse is matched against the next expected completion
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done != '0) begin
      if (sbq.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = sbq.pop_front();
        check("done_core", 32'(done), 32'(4'b0001 << e.core));
        check("done_gnt", 32'(gnt), 32'(4'b0001 << e.core));
        check("done_rdata", 32'(rdata), 32'(e.rd));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NCORES-1:0] d;
    int t0, tprev;
    logic [NCORES-1:0] order [4];

    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = pre(8'(i));
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);

    // Reset asserted mid-access: everything clears at once, no done
    @(negedge clk);
    rst = 1'b0;
    addr[2*AW +: AW] = 8'h40;
    req = 4'b0100;
    @(posedge clk); #1;
    check("pre_rst_gnt", 32'(gnt), 32'h4);
    check("pre_rst_mem_en", 32'(mem_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_gnt", 32'(gnt), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_mem_en", 32'(mem_en), 32'd0);
    req = '0;
    @(negedge clk);
    rst = 1'b0;

    // Contention: all four request, each drops after its own done
    for (int i = 0; i < 4; i++) begin
      addr[i*AW +: AW] = 8'h20 + 8'(i);
      push_read(i, 8'h20 + 8'(i));
    end
    @(negedge clk);
    t0 = cyc;
    tprev = 0;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_any_done(d);
      check("cont_order", 32'(d), 32'(4'b0001 << i));
      if (i == 0) check("cont_latency", cyc - t0, 3);
      else        check("cont_period", cyc - tprev, MEM_LAT + 2);
      tprev = cyc;
      req = req & ~d;
    end
    repeat (2) @(posedge clk);

    // Single read by core 1; address changed after grant must be ignored
    @(negedge clk);
    addr[1*AW +: AW] = 8'h3C;
    we = '0;
    push_read(1, 8'h3C);
    req = 4'b0010;
    @(posedge clk); #1;
    check("rd_gnt", 32'(gnt), 32'h2);
    check("rd_mem_addr", 32'(mem_addr), 32'h3C);
    check("rd_mem_en", 32'(mem_en), 32'd1);
    check("rd_mem_we", 32'(mem_we), 32'd0);
    addr[1*AW +: AW] = 8'h00;
    @(posedge clk); #1;
    check("rd_done_early", 32'(done), 32'd0);
    check("rd_addr_held", 32'(mem_addr), 32'h3C);
    @(posedge clk); #1;
    check("rd_done", 32'(done), 32'h2);
    check("rd_rdata", 32'(rdata), 32'hA5);
    req = '0;
    repeat (3) @(posedge clk);

    // Single write by core 0; rdata must keep the last read value
    @(negedge clk);
    addr[0 +: AW]  = 8'h10;
    wdata[0 +: DW] = 8'h77;
    we = 4'b0001;
    push_write(0);
    req = 4'b0001;
    @(posedge clk); #1;
    check("wr_mem_we1", 32'(mem_we), 32'd1);
    check("wr_mem_wdata1", 32'(mem_wdata), 32'h77);
    check("wr_mem_addr", 32'(mem_addr), 32'h10);
    wdata[0 +: DW] = 8'h00;
    @(posedge clk); #1;
    check("wr_mem_we2", 32'(mem_we), 32'd1);
    check("wr_mem_wdata2", 32'(mem_wdata), 32'h77);
    @(posedge clk); #1;
    check("wr_done", 32'(done), 32'h1);
    check("wr_rdata_kept", 32'(rdata), 32'hA5);
    check("wr_mem_en_off", 32'(mem_en), 32'd0);
    req = '0;
    we  = '0;
    check("wr_mem_content", 32'(mem[8'h10]), 32'h77);
    repeat (3) @(posedge clk);

    // Abandoned request: core 2 drops req right after the grant
    @(negedge clk);
    addr[2*AW +: AW] = 8'h50;
    push_read(2, 8'h50);
    req = 4'b0100;
    @(posedge clk); #1;
    req = '0;
    wait_any_done(d);
    check("abandon_done", 32'(d), 32'h4);
    @(posedge clk); #1;
    check("abandon_idle_gnt", 32'(gnt), 32'd0);
    repeat (2) @(posedge clk);

    // Wrap: rr_ptr now 3, cores 3 and 0 request together
    @(negedge clk);
    addr[3*AW +: AW] = 8'h63;
    addr[0 +: AW]    = 8'h60;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    order[0] = 4'b0001; order[1] = 4'b1000;
    push_read(0, 8'h60);
    push_read(3, 8'h63);
`else
    order[0] = 4'b1000; order[1] = 4'b0001;
    push_read(3, 8'h63);
    push_read(0, 8'h60);
`endif
    req = 4'b1001;
    for (int i = 0; i < 2; i++) begin
      wait_any_done(d);
      check("wrap_order", 32'(d), 32'(order[i]));
      req = req & ~d;
    end
    repeat (3) @(posedge clk);

`ifdef DMEM_ARB_FIXED_PRIO_EN
    // Fixed priority: core 0 wins every slot while it keeps requesting
    @(negedge clk);
    for (int i = 0; i < 4; i++) addr[i*AW +: AW] = 8'h20 + 8'(i);
    for (int i = 0; i < 3; i++) push_read(0, 8'h20);
    req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      wait_any_done(d);
      check("prio_core0", 32'(d), 32'h1);
    end
    req = '0;
    repeat (3) @(posedge clk);
`endif

    repeat (3) @(posedge clk);
    check("sb_empty", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
